// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Reused by the receiver, transmitter and the bus interface.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int NB_DATA_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/baud_rate_gen.sv
// Oversample tick generator: one-clk tick every BAUD_DIV clocks.
// Shared between the UART receiver and transmitter.
module baud_rate_gen #(
    parameter int BAUD_DIV = 163
) (
    input  logic clk,
    input  logic i_rst,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, mid-bit sampling.
// Reports good frames on o_rxDone and bad stop bits on o_frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_STOP  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxDone,
    output logic               o_frame_err
);

    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    uart_state_t        state, state_n;
    logic [3:0]         s, s_n;
    logic [NW-1:0]      n, n_n;
    logic [NB_DATA-1:0] sh, sh_n;
    logic [NB_DATA-1:0] data_q, data_n;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic [1:0]         sync;
    logic               rx_s;
    logic               tick;

    baud_rate_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .i_rst (i_rst),
        .tick  (tick)
    );

    assign rx_s        = sync[1];
    assign o_data      = data_q;
    assign o_rxDone    = done_q;
    assign o_frame_err = err_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync   <= 2'b11;
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            sh     <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync   <= {sync[0], i_rx};
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            sh     <= sh_n;
            data_q <= data_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        sh_n    = sh;
        data_n  = data_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            // Half a bit in: confirm the start bit is still low.
            START: begin
                if (tick) begin
                    if (s == 4'(OVERSAMPLE / 2 - 1)) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == 4'(OVERSAMPLE - 1)) begin
                        s_n  = '0;
                        sh_n = {rx_s, sh[NB_DATA-1:1]};
                        if (n == NW'(NB_DATA - 1)) begin
                            state_n = STOP;
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == 4'(NB_STOP - 1)) begin
                        state_n = IDLE;
                        if (rx_s) begin
                            data_n = sh;
                            done_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD_DIV=4 (64 clk per bit).
// Stimulus pushes expected pulses; a monitor pops and compares them.
module tb_uart_rx;

    localparam int BIT = 64;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rxDone;
    logic       o_frame_err;

    exp_t       q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    int         prev_done_cyc = 0;
    bit         prev_pulse = 1'b0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .NB_DATA  (8),
        .NB_STOP  (16),
        .BAUD_DIV (4)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rxDone    (o_rxDone),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        bit   pulse;
        pulse = o_rxDone || o_frame_err;
        if (pulse) begin
            check("pulse_exclusive", int'(o_rxDone && o_frame_err), 0);
            check("pulse_one_clk", int'(prev_pulse), 0);
            if (o_rxDone) begin
                prev_done_cyc = done_cyc;
                done_cyc      = cyc;
            end
            if (q.size() == 0) begin
                check("unexpected_pulse", int'({o_rxDone, o_frame_err}), 0);
            end else begin
                e = q.pop_front();
                check("pulse_kind_err", int'(o_frame_err), int'(e.err));
                check("o_data", int'(o_data), int'(e.data));
            end
        end
        prev_pulse = pulse;
    end

    task automatic drive_bit(input logic v, input int ncyc);
        i_rx = v;
        repeat (ncyc) @(posedge clk);
    endtask

    // Bad stop bit is low only past its mid-point so the tail looks like a glitch.
    task automatic send_frame(input logic [7:0] d, input bit good);
        exp_t e;
        e.err  = !good;
        e.data = good ? d : last_good;
        if (good) last_good = d;
        q.push_back(e);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        if (good) begin
            drive_bit(1'b1, BIT);
        end else begin
            drive_bit(1'b0, 40);
            drive_bit(1'b1, BIT - 40);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_o_data", int'(o_data), 0);
        check("rst_o_rxDone", int'(o_rxDone), 0);
        check("rst_o_frame_err", int'(o_frame_err), 0);
        repeat (20) @(posedge clk);

        send_frame(8'hA5, 1'b1);
        wait_drain("drain_a5", 200);
        repeat (20) @(posedge clk);

        send_frame(8'h00, 1'b0);
        wait_drain("drain_err00", 200);
        repeat (150) @(posedge clk);
        check("hold_after_err", int'(o_data), 'hA5);

        drive_bit(1'b0, 12);
        drive_bit(1'b1, 100);
        send_frame(8'h3C, 1'b1);
        wait_drain("drain_glitch_3c", 200);
        repeat (20) @(posedge clk);

        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_drain("drain_b2b", 200);
        check("b2b_spacing", done_cyc - prev_done_cyc, 640);
        repeat (20) @(posedge clk);

        drive_bit(1'b0, BIT);
        drive_bit(1'b1, 3 * BIT + 32);
        i_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_o_data", int'(o_data), 0);
        check("midrst_o_rxDone", int'(o_rxDone), 0);
        check("midrst_o_frame_err", int'(o_frame_err), 0);
        @(posedge clk);
        i_rst = 1'b0;
        last_good = 8'h00;
        repeat (700) @(posedge clk);
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81", 200);
        repeat (20) @(posedge clk);

        e.err  = 1'b1;
        e.data = 8'h81;
        repeat (3) q.push_back(e);
        i_rx = 1'b0;
        wait_drain("drain_break", 3 * 640 + 200);
        repeat (5) @(posedge clk);
        i_rx = 1'b1;
        repeat (300) @(posedge clk);
        check("break_o_data", int'(o_data), 'h81);
        check("queue_empty_end", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
